// File: rtl/disp2depth_if.sv
// disp2depth_if: disparity-in / depth-out handshake bundle for disp2depth.
interface disp2depth_if #(parameter int DW = 6, parameter int AW = 11, parameter int ZW = 16);
    logic          d_valid;
    logic          d_ready;
    logic [DW-1:0] d;
    logic [AW-1:0] d_addr;
    logic          d_sol;
    logic          z_valid;
    logic          z_ready;
    logic [ZW-1:0] z;
    logic [AW-1:0] z_addr;
    logic          busy;
    modport master (output d_valid, d, d_addr, d_sol, z_ready,
                    input  d_ready, z_valid, z, z_addr, busy);
    modport slave  (input  d_valid, d, d_addr, d_sol, z_ready,
                    output d_ready, z_valid, z, z_addr, busy);
endinterface

// File: rtl/disp2depth.sv
// disp2depth: depth z = floor(K/d) via a one-bit-per-clock restoring divider; d==0 saturates.
// Define D2D_MEDIAN3_EN to pass accepted disparities through a causal per-line 3-tap median.
module disp2depth #(
    parameter int DW = 6,
    parameter int AW = 11,
    parameter int ZW = 16,
    parameter int K  = 4096
) (
    input logic        clk,
    input logic        rst_n,
    disp2depth_if.slave io
);
    localparam int CW = $clog2(ZW);
    typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW:0]   rem_q, rem_d, sh;
    logic [ZW-1:0] quo_q, quo_d, z_q, z_d;
    logic [DW-1:0] dv_q, dv_d, eff;
    logic [AW-1:0] addr_q, addr_d;
    logic          acc, ge;
    assign acc = io.d_valid && state_q == IDLE;
`ifdef D2D_MEDIAN3_EN
    logic [DW-1:0] h1_q, h1_d, h2_q, h2_d, lo, hi;
    logic [1:0]    hc_q, hc_d;
    // Median of (h2, h1, d) is d clamped into [min(h2,h1), max(h2,h1)].
    always_comb begin
        lo   = h2_q < h1_q ? h2_q : h1_q;
        hi   = h2_q < h1_q ? h1_q : h2_q;
        eff  = (io.d_sol || hc_q != 2'd2) ? io.d : (io.d < lo ? lo : (io.d > hi ? hi : io.d));
        h1_d = acc ? io.d : h1_q;
        h2_d = acc ? (io.d_sol ? '0 : h1_q) : h2_q;
        hc_d = !acc ? hc_q : (io.d_sol ? 2'd1 : (hc_q == 2'd2 ? 2'd2 : hc_q + 2'd1));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q <= '0;
            h2_q <= '0;
            hc_q <= '0;
        end else begin
            h1_q <= h1_d;
            h2_q <= h2_d;
            hc_q <= hc_d;
        end
    end
`else
    logic unused_sol;
    assign unused_sol = io.d_sol;
    assign eff = io.d;
`endif
    assign sh = {rem_q[DW-1:0], quo_q[ZW-1]};
    assign ge = sh >= {1'b0, dv_q};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dv_d    = dv_q;
        addr_d  = addr_q;
        z_d     = z_q;
        if (acc) begin
            dv_d    = eff;
            addr_d  = io.d_addr;
            rem_d   = '0;
            quo_d   = ZW'(K);
            cnt_d   = CW'(ZW - 1);
            state_d = eff == '0 ? OUT : DIV;
            z_d     = eff == '0 ? '1 : z_q;
        end
        if (state_q == DIV) begin
            rem_d = ge ? sh - {1'b0, dv_q} : sh;
            quo_d = {quo_q[ZW-2:0], ge};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = OUT;
                z_d     = {quo_q[ZW-2:0], ge};
            end
        end
        if (state_q == OUT && io.z_ready) state_d = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dv_q    <= '0;
            addr_q  <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dv_q    <= dv_d;
            addr_q  <= addr_d;
            z_q     <= z_d;
        end
    end
    assign io.d_ready = state_q == IDLE;
    assign io.z_valid = state_q == OUT;
    assign io.busy    = state_q != IDLE;
    assign io.z       = z_q;
    assign io.z_addr  = addr_q;
endmodule

// File: tb/tb_disp2depth.sv
// tb_disp2depth: directed and random checks of disp2depth against a floor(K/d) scoreboard.
module tb_disp2depth;
    localparam int DW = 6, AW = 11, ZW = 16, K = 4096;
    logic clk = 0, rst_n = 0;
    logic zr_dir = 1, zr_rnd = 0, rnd_en = 0;
    int n_cmp = 0, n_err = 0, n_push = 0, n_pop = 0;
    logic [AW+ZW-1:0] sb[$];
    always #5 clk = ~clk;
    disp2depth_if #(.DW(DW), .AW(AW), .ZW(ZW)) bus();
    assign bus.z_ready = rnd_en ? zr_rnd : zr_dir;
    disp2depth #(.DW(DW), .AW(AW), .ZW(ZW), .K(K)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

    task automatic chk(string tag, int obs, int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int zmod(int dd);
        return dd == 0 ? (1 << ZW) - 1 : K / dd;
    endfunction

`ifdef D2D_MEDIAN3_EN
    int hist[$];
    function automatic int eff_model(int dd, bit sol);
        int e = dd;
        if (sol) hist.delete();
        if (hist.size() == 2) begin
            int a = hist[0];
            int b = hist[1];
            int mx = a > b ? a : b;
            int mn = a < b ? a : b;
            mx = mx > dd ? mx : dd;
            mn = mn < dd ? mn : dd;
            e = a + b + dd - mx - mn;
        end
        hist.push_back(dd);
        if (hist.size() > 2) void'(hist.pop_front());
        return e;
    endfunction
`else
    function automatic int eff_model(int dd, bit sol);
        return sol ? dd : dd;
    endfunction
`endif

    // Scoreboard pop on every output handshake (inputs are stable at negedge).
    always @(negedge clk) begin
        if (rst_n && bus.z_valid && bus.z_ready) begin
            n_pop++;
            if (sb.size() == 0) chk("sb_underflow", 0, 1);
            else begin
                logic [AW+ZW-1:0] e;
                e = sb.pop_front();
                chk("sb_z", bus.z, e[ZW-1:0]);
                chk("sb_addr", bus.z_addr, e[AW+ZW-1:ZW]);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        zr_rnd = 1'($urandom_range(0, 1));
    end

    // Leaves d_valid high; returns #1 after the accept edge.
    task automatic send(int dd, int addr, bit sol, int expz);
        int t = 0;
        bus.d_valid = 1;
        bus.d = DW'(dd);
        bus.d_addr = AW'(addr);
        bus.d_sol = sol;
        while (!bus.d_ready && t < 500) begin
            cyc();
            t++;
        end
        chk("accept_timeout", int'(t < 500), 1);
        sb.push_back({AW'(addr), ZW'(expz)});
        n_push++;
        cyc();
    endtask

    task automatic run_one(int dd, int addr, int expz, int exp_lat);
        int lat = 1;
        bit busy_ok = 1;
        send(dd, addr, 1, expz);
        bus.d_valid = 0;
        while (!bus.z_valid && lat < 100) begin
            busy_ok &= bus.busy;
            cyc();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("z", bus.z, expz);
        chk("z_addr", bus.z_addr, addr);
        chk("busy_during", int'(busy_ok && bus.busy), 1);
        cyc();
        chk("d_ready_after", bus.d_ready, 1);
        chk("z_valid_after", bus.z_valid, 0);
    endtask

    initial begin
        bus.d_valid = 0;
        bus.d = '0;
        bus.d_addr = '0;
        bus.d_sol = 0;
        repeat (3) cyc();
        chk("rst_d_ready", bus.d_ready, 1);
        chk("rst_z_valid", bus.z_valid, 0);
        chk("rst_z", bus.z, 0);
        chk("rst_z_addr", bus.z_addr, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1;
        cyc();
        run_one(8, 100, 512, 17);
        run_one(0, 101, 16'hFFFF, 1);
        run_one(63, 102, 65, 17);
        run_one(1, 103, 4096, 17);
        // Backpressure: result held, new request ignored.
        zr_dir = 0;
        send(5, 7, 1, 819);
        bus.d = 6'd9;
        bus.d_addr = 11'd8;
        for (int t = 0; t < 100 && !bus.z_valid; t++) cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_z", bus.z, 819);
            chk("bp_z_addr", bus.z_addr, 7);
            chk("bp_d_ready", bus.d_ready, 0);
            chk("bp_z_valid", bus.z_valid, 1);
            cyc();
        end
        bus.d_valid = 0;
        zr_dir = 1;
        cyc();
        chk("bp_release_d_ready", bus.d_ready, 1);
        // Reset in the middle of a division.
        send(20, 3, 1, 204);
        bus.d_valid = 0;
        repeat (5) cyc();
        rst_n = 0;
        #1;
        chk("midrst_z_valid", bus.z_valid, 0);
        chk("midrst_d_ready", bus.d_ready, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_z", bus.z, 0);
        chk("midrst_z_addr", bus.z_addr, 0);
        n_push -= sb.size();
        sb.delete();
        cyc();
        rst_n = 1;
        cyc();
        run_one(16, 44, 256, 17);
`ifdef D2D_MEDIAN3_EN
        send(10, 1, 1, 409);
        send(40, 2, 0, 102);
        send(12, 3, 0, 341);
        send(7, 4, 1, 585);
        bus.d_valid = 0;
        for (int t = 0; t < 200 && sb.size() != 0; t++) cyc();
        chk("med_drain", sb.size(), 0);
`endif
        // Random back-to-back traffic with random backpressure.
        rnd_en = 1;
        for (int i = 0; i < 40; i++) begin
            int dd = i == 1 ? 0 : (i == 2 ? 63 : int'($urandom_range(0, 63)));
            bit sol = (i == 0) || ($urandom_range(0, 3) == 0);
            send(dd, 200 + i, sol, zmod(eff_model(dd, sol)));
        end
        bus.d_valid = 0;
        for (int t = 0; t < 2000 && (sb.size() != 0 || bus.z_valid); t++) cyc();
        rnd_en = 0;
        chk("rnd_drain", sb.size(), 0);
        chk("rnd_count", n_pop, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
